// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the block-sum accumulator: width derivation helpers
// and the two-state controller encoding.
package sum_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Ceiling log2; COUNT is a power of two, so this is exact in practice.
  function automatic int log2c(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // The total must hold COUNT * (2^DATA_W - 1) without wrapping.
  function automatic int acc_width(input int data_w, input int count);
    return data_w + log2c(count);
  endfunction

  // The count field must be able to hold COUNT itself, not just COUNT-1.
  function automatic int cnt_width(input int count);
    return log2c(count) + 1;
  endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Streaming accumulator: totals blocks of COUNT unsigned samples into a widened
// result, with early partial emission on flush and a one-entry result buffer.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int COUNT  = 4,
  localparam int ACC_W  = acc_width(DATA_W, COUNT),
  localparam int CNT_W  = cnt_width(COUNT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             in_fire;
  logic             out_fire;
  logic [ACC_W-1:0] data_ext;
  logic [ACC_W-1:0] acc_add;
  logic [CNT_W-1:0] cnt_add;
  logic [ACC_W-1:0] sum_sel;
  logic [CNT_W-1:0] cnt_sel;
  logic             close_block;

  // In HOLD the result slot is freed in the same cycle it is consumed, so the
  // upstream may push a sample exactly when the downstream takes the result.
  assign in_ready  = !reset && ((state == ACCUM) || out_ready);
  assign out_valid = (state == HOLD);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign data_ext  = {{(ACC_W - DATA_W){1'b0}}, in_data};

  // Candidate total including this cycle's sample, and whether the block ends
  // now (full count reached, or a flush with at least one sample in hand).
  always_comb begin
    acc_add     = acc + data_ext;
    cnt_add     = cnt + CNT_ONE;
    sum_sel     = in_fire ? acc_add : acc;
    cnt_sel     = in_fire ? cnt_add : cnt;
    close_block = 1'b0;
    if (state == ACCUM) begin
      close_block = (in_fire && (cnt_add == CNT_FULL)) ||
                    (flush && (cnt_sel != CNT_ZERO));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (close_block) begin
            out_sum   <= sum_sel;
            out_count <= cnt_sel;
            acc       <= '0;
            cnt       <= '0;
            state     <= HOLD;
          end else begin
            acc <= sum_sel;
            cnt <= cnt_sel;
          end
        end
        HOLD: begin
          // A sample accepted here opens the next block; flush is not queued.
          if (out_fire) begin
            state <= ACCUM;
            if (in_fire) begin
              acc <= data_ext;
              cnt <= CNT_ONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_sum_accumulator;

  localparam int DATA_W = 8;
  localparam int COUNT  = 4;
  localparam int ACC_W  = 10;
  localparam int CNT_W  = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;

  int checks = 0;
  int errors = 0;

  // Reference model: a result slot flag, the samples of the open block, and
  // the last emitted total/count.
  bit m_hold = 1'b0;
  int m_blk[$];
  int m_sum = 0;
  int m_cnt = 0;

  sum_accumulator #(.DATA_W(DATA_W), .COUNT(COUNT)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count)
  );

  always #5 clock = ~clock;

  task automatic model_step(input bit rst, input bit iv, input int d,
                            input bit fl, input bit ordy);
    int total;
    if (rst) begin
      m_hold = 1'b0;
      m_blk.delete();
      m_sum = 0;
      m_cnt = 0;
    end else if (!m_hold) begin
      if (iv) m_blk.push_back(d);
      if ((m_blk.size() == COUNT) || (fl && (m_blk.size() > 0))) begin
        total = 0;
        foreach (m_blk[i]) total += m_blk[i];
        m_sum = total;
        m_cnt = m_blk.size();
        m_blk.delete();
        m_hold = 1'b1;
      end
    end else if (ordy) begin
      m_hold = 1'b0;
      if (iv) m_blk.push_back(d);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, in_ready is
  // checked before the rising edge, registered outputs just after it.
  task automatic applyStimulus(input bit rst, input bit iv, input int d,
                               input bit fl, input bit ordy);
    logic             exp_ready;
    logic [ACC_W-1:0] exp_sum;
    logic [CNT_W-1:0] exp_cnt;
    @(negedge clock);
    reset     = rst;
    in_valid  = iv;
    in_data   = d[DATA_W-1:0];
    flush     = fl;
    out_ready = ordy;
    #1;
    exp_ready = rst ? 1'b0 : (m_hold ? ordy : 1'b1);
    checks++;
    assert (in_ready === exp_ready) else begin
      errors++;
      $error("[TB] FAIL in_ready observed=%0b expected=%0b", in_ready, exp_ready);
    end
    @(posedge clock);
    model_step(rst, iv, d, fl, ordy);
    #1;
    checkOutput();
    exp_sum = m_sum[ACC_W-1:0];
    exp_cnt = m_cnt[CNT_W-1:0];
    checks++;
    assert (out_sum === exp_sum) else begin
      errors++;
      $error("[TB] FAIL out_sum observed=%0d expected=%0d", out_sum, exp_sum);
    end
    checks++;
    assert (out_count === exp_cnt) else begin
      errors++;
      $error("[TB] FAIL out_count observed=%0d expected=%0d", out_count, exp_cnt);
    end
  endtask

  task automatic checkOutput();
    checks++;
    assert (out_valid === m_hold) else begin
      errors++;
      $error("[TB] FAIL out_valid observed=%0b expected=%0b", out_valid, m_hold);
    end
  endtask

  task automatic feed(input int d);
    applyStimulus(1'b0, 1'b1, d, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 77, 1'b1, 1'b1);

    // Basic block of four, then a full-scale block to exercise the widened total.
    feed(10); feed(20); feed(30); feed(40);
    feed(255); feed(255); feed(255); feed(255);
    idle(2);

    // Backpressure: result held, input stalled, then simultaneous fire.
    feed(1); feed(1); feed(1); feed(1);
    applyStimulus(1'b0, 1'b1, 9, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 9, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b1);
    feed(2); feed(3); feed(4);
    idle(2);

    // Flush of a partial block, then flush with nothing pending.
    feed(7); feed(8);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
    idle(1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
    idle(1);

    // Flush arriving with the last sample, and flush on the COUNT-th sample.
    feed(5); feed(5);
    applyStimulus(1'b0, 1'b1, 5, 1'b1, 1'b1);
    idle(1);
    feed(6); feed(6); feed(6);
    applyStimulus(1'b0, 1'b1, 6, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(2);

    // Reset mid-block and mid-hold discards everything.
    feed(9); feed(9); feed(9);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b1);
    feed(1); feed(1); feed(1); feed(1);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(1);

    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 255)),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
